// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM encoding, flag bundle.
package alu_pkg;

    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_SRA = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sub=1 computes a + ~b + 1, carry=1 means no borrow.
module alu_addsub #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    // Invert b for subtraction; the +1 enters as the carry-in.
    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);

    assign sum      = full[WIDTH-1:0];
    assign carry    = full[WIDTH];
    // Signed overflow: operands agree in sign but the sum does not.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// Registered handshake ALU with flag outputs.
// Optional macro SEQ_ALU_BARREL_SHIFT_EN: single-cycle barrel shifts instead of
// the iterative one-bit-per-cycle shifter.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CTRL_W-1:0] control,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    output logic              overflow
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    alu_state_t         state_q, state_d;
    logic               ready_en_q;
    logic               accept;
    logic [WIDTH-1:0]   result_d;
    alu_flags_t         flags_d;
    logic               out_valid_d;

    logic               as_sub;
    logic [WIDTH-1:0]   as_sum;
    logic               as_carry;
    logic               as_ovf;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   op_res_c;
    logic               op_carry_c;
    logic               op_ovf_c;

`ifndef SEQ_ALU_BARREL_SHIFT_EN
    logic               op_iter_c;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [CTRL_W-1:0]  sop_q, sop_d;
    logic [WIDTH-1:0]   step_c;

    // One-bit shift of the working register for the latched shift kind.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                    input logic [CTRL_W-1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            ALU_SLL: r = {v[WIDTH-2:0], 1'b0};
            ALU_SRL: r = {1'b0, v[WIDTH-1:1]};
            default: r = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
        return r;
    endfunction
`endif

    assign as_sub = (control == ALU_SUB) || (control == ALU_SLT);
    assign shamt  = b[SHAMT_W-1:0];

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (as_sub),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    // in_ready stays low until the first clock after reset release.
    assign in_ready = ready_en_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Single-cycle evaluation of the incoming operation.
    always_comb begin
        op_res_c   = '0;
        op_carry_c = 1'b0;
        op_ovf_c   = 1'b0;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
        op_iter_c  = 1'b0;
`endif
        case (control)
            ALU_ADD, ALU_SUB: begin
                op_res_c   = as_sum;
                op_carry_c = as_carry;
                op_ovf_c   = as_ovf;
            end
            ALU_AND: op_res_c = a & b;
            ALU_OR:  op_res_c = a | b;
            ALU_XOR: op_res_c = a ^ b;
            ALU_SLT: op_res_c = WIDTH'(as_sum[WIDTH-1] ^ as_ovf);
`ifdef SEQ_ALU_BARREL_SHIFT_EN
            ALU_SLL: op_res_c = a << shamt;
            ALU_SRL: op_res_c = a >> shamt;
            ALU_SRA: op_res_c = WIDTH'($signed(a) >>> shamt);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                op_res_c  = a;
                op_iter_c = (shamt != '0);
            end
`endif
            default: op_res_c = '0;
        endcase
    end

`ifndef SEQ_ALU_BARREL_SHIFT_EN
    assign step_c = shift_step(work_q, sop_q);
`endif

    // Next-state, result and flag selection.
    always_comb begin
        state_d     = state_q;
        result_d    = result;
        flags_d     = '{zero: zero, negative: negative, carry: carry, overflow: overflow};
        out_valid_d = out_valid;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
        work_d      = work_q;
        cnt_d       = cnt_q;
        sop_d       = sop_q;
`endif
        case (state_q)
            IDLE: ;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
            SHIFT: begin
                work_d = step_c;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d     = DONE;
                    result_d    = step_c;
                    flags_d     = '{zero: (step_c == '0), negative: step_c[WIDTH-1],
                                    carry: 1'b0, overflow: 1'b0};
                    out_valid_d = 1'b1;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
`ifndef SEQ_ALU_BARREL_SHIFT_EN
            if (op_iter_c) begin
                state_d     = SHIFT;
                work_d      = a;
                cnt_d       = shamt;
                sop_d       = control;
                out_valid_d = 1'b0;
            end else
`endif
            begin
                state_d     = DONE;
                result_d    = op_res_c;
                flags_d     = '{zero: (op_res_c == '0), negative: op_res_c[WIDTH-1],
                                carry: op_carry_c, overflow: op_ovf_c};
                out_valid_d = 1'b1;
            end
        end
    end

    // State, output and working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            negative   <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
            work_q     <= '0;
            cnt_q      <= '0;
            sop_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            result     <= result_d;
            zero       <= flags_d.zero;
            negative   <= flags_d.negative;
            carry      <= flags_d.carry;
            overflow   <= flags_d.overflow;
            out_valid  <= out_valid_d;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            sop_q      <= sop_d;
`endif
        end
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Accepts one operation per handshake and returns a registered result with a full flag set (zero, negative, carry, overflow).
- Adds XOR, set-less-than and three shift operations; shifts run iteratively, one bit per cycle.
- Sits between the ID/EX operand registers and the EX/MEM stage; stalls upstream via in_ready.

Parameters:
- WIDTH, 64, operand and result width in bits; must be ≥ 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived localparam, not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and control valid.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A, two's complement.
- b  in  WIDTH  operand B; b[SHAMT_W-1:0] is the shift amount for shifts.
- control  in  4  operation code.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  adder carry-out; 0 for non-arithmetic ops.
- overflow  out  1  signed overflow; 0 for non-arithmetic ops.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE; result=0, zero=0, negative=0, carry=0, overflow=0, out_valid=0; in_ready=1 one cycle after rst_n deasserts.
- Reset asserted mid-operation aborts it immediately. No partial result is ever presented.
- Operation codes:
  - 0010 ADD
  - 0110 SUB
  - 0000 AND
  - 0001 OR
  - 0011 XOR
  - 0111 SLT (signed)
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
  - any other code: result=0, all flags 0 except zero=1.
- States:
  - IDLE: waiting for an operation.
  - SHIFT: iterating a shift.
  - DONE: holding out_valid=1.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept occurs when in_valid && in_ready.
- Non-shift ops, or shifts with amount 0: result registered, state→DONE. An accept in cycle N gives out_valid in cycle N+1.
- Shifts with amount k>0: state→SHIFT. The working register moves one bit per cycle and a down-counter is loaded with k. When the counter reaches 0, state→DONE, giving out_valid in cycle N+1+k.
- Shift rules: SRA replicates the sign bit; SLL and SRL fill with zeros.
- DONE holds result and flags stable until out_ready=1.
  - If out_ready=1 and in_valid=1 in the same cycle, the new operation is accepted (back-to-back, 1 result per cycle for non-shift ops).
  - Otherwise state→IDLE.
- ADD/SUB are WIDTH-bit modular.
  - SUB is computed as a + ~b + 1, and carry is that carry-out (1 = no borrow).
  - overflow = operand signs equal (after b inversion for SUB) and result sign differs.
- SLT: result = {WIDTH-1 zeros, diff_sign XOR diff_overflow}; carry=0, overflow=0.
- Flags are registered together with result.
- Inputs are sampled only on accept; changes on a, b or control while busy are ignored.
- out_ready is ignored outside DONE.

Optional Feature:
- Macro: SEQ_ALU_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter and complete like other ops (out_valid at N+1); the SHIFT state and counter are not generated.
- Undefined: iterative shifting as specified above.
- All other behaviour is identical with or without the macro.

Decomposition:
- Shared package alu_pkg holds:
  - control-code localparams (ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA);
  - the state encoding (IDLE, SHIFT, DONE).
- Sub-module alu_addsub (WIDTH-parametrised): inputs a, b, sub; outputs sum, carry, overflow. It is shared by ADD, SUB and SLT.

Test Plan (WIDTH=64):
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 → result 0x8000_0000_0000_0000, overflow=1, negative=1, carry=0, out_valid one cycle after accept.
- SUB a=5, b=5 → result 0, zero=1, carry=1. SLT a=-1, b=1 → result 1.
- SRA a=0x8000_0000_0000_0000, b=63 → result all ones; out_valid 64 cycles after accept (iterative build), 1 cycle (SEQ_ALU_BARREL_SHIFT_EN build).
- Back-to-back: ADD 1+2 then OR 0xF0|0x0F with out_ready held 1 → results 3 and 0xFF on consecutive cycles; in_ready never drops.
- Backpressure: out_ready=0 for 5 cycles after XOR 0xAA^0xFF → result 0x55 held stable, in_ready=0, a/b changes ignored.
- Reset asserted during SRL b=40 at shift cycle 10 → outputs 0 asynchronously, state IDLE; a following AND 0xC & 0xA returns 0x8.
